// File: rtl/addr8s_fault_monitor_if.sv
// Bus between the operand sequencer/campaign controller (master) and the adder fault monitor (slave).
// The first-mismatch capture fields exist only when ADDR8S_MON_FIRST_FAIL_EN is defined.
`default_nettype none

interface addr8s_fault_monitor_if #(
   parameter int CNT_W   = 16,
   parameter int LIMIT_W = 16
);
   logic               start;
   logic               clear;
   logic [LIMIT_W-1:0] run_len;
   logic               in_valid;
   logic               in_ready;
   logic [7:0]         a;
   logic [7:0]         b;
   logic [8:0]         dut_sum;
   logic               res_valid;
   logic               res_mismatch;
   logic [8:0]         res_syndrome;
   logic [CNT_W-1:0]   vec_count;
   logic [CNT_W-1:0]   err_count;
   logic [8:0]         bit_err_mask;
   logic               busy;
   logic               done;
`ifdef ADDR8S_MON_FIRST_FAIL_EN
   logic               ff_valid;
   logic [7:0]         ff_a;
   logic [7:0]         ff_b;
   logic [8:0]         ff_sum;
   logic [CNT_W-1:0]   ff_index;

   modport master (
      output start, clear, run_len, in_valid, a, b, dut_sum,
      input  in_ready, res_valid, res_mismatch, res_syndrome,
      input  vec_count, err_count, bit_err_mask, busy, done,
      input  ff_valid, ff_a, ff_b, ff_sum, ff_index
   );

   modport slave (
      input  start, clear, run_len, in_valid, a, b, dut_sum,
      output in_ready, res_valid, res_mismatch, res_syndrome,
      output vec_count, err_count, bit_err_mask, busy, done,
      output ff_valid, ff_a, ff_b, ff_sum, ff_index
   );
`else
   modport master (
      output start, clear, run_len, in_valid, a, b, dut_sum,
      input  in_ready, res_valid, res_mismatch, res_syndrome,
      input  vec_count, err_count, bit_err_mask, busy, done
   );

   modport slave (
      input  start, clear, run_len, in_valid, a, b, dut_sum,
      output in_ready, res_valid, res_mismatch, res_syndrome,
      output vec_count, err_count, bit_err_mask, busy, done
   );
`endif
endinterface

`default_nettype wire

// File: rtl/addr8s_fault_monitor.sv
// Two-stage checker for the 8-bit signed adder: golden compare plus run statistics.
// Optional first-mismatch capture enabled by defining ADDR8S_MON_FIRST_FAIL_EN.
`default_nettype none

module addr8s_fault_monitor #(
   parameter int CNT_W   = 16,
   parameter int LIMIT_W = 16
) (
   input  wire logic               clk,
   input  wire logic               rst,
   addr8s_fault_monitor_if.slave   mon
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [LIMIT_W-1:0] run_len_q, run_len_d;
   logic [LIMIT_W-1:0] acc_q, acc_d;

   logic               s1_valid_q;
   logic [7:0]         s1_a_q, s1_b_q;
   logic [8:0]         s1_sum_q;

   logic               res_valid_q;
   logic               res_mismatch_q;
   logic [8:0]         res_syndrome_q;

   logic [CNT_W-1:0]   vec_count_q, vec_count_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic [8:0]         mask_q, mask_d;

   logic               w_in_ready;
   logic               w_busy;
   logic               w_done;
   logic               w_xfer;
   logic               w_start_ok;
   logic               w_clear_ok;
   logic               w_last_accept;
   logic [8:0]         w_golden;
   logic [8:0]         w_syn;
   logic               w_mis;

   assign w_xfer        = mon.in_valid & w_in_ready;
   assign w_start_ok    = mon.start & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign w_clear_ok    = mon.clear & ~mon.start & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign w_last_accept = w_xfer & ((acc_q + LIMIT_W'(1)) == run_len_q);

   // Sign-extending to 9 bits makes the golden sum exact for every operand pair.
   assign w_golden = {s1_a_q[7], s1_a_q} + {s1_b_q[7], s1_b_q};
   assign w_syn    = s1_sum_q ^ w_golden;
   assign w_mis    = |w_syn;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (mon.start) begin
               state_d = (mon.run_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last_accept) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!s1_valid_q && !res_valid_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (mon.start) begin
               state_d = (mon.run_len == '0) ? S_DONE : S_RUN;
            end else if (mon.clear) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready = (state_q == S_RUN) && (acc_q < run_len_q);
      w_busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
      w_done     = (state_q == S_DONE);
   end

   always_comb begin
      run_len_d = run_len_q;
      acc_d     = acc_q;
      if (w_start_ok) begin
         run_len_d = mon.run_len;
         acc_d     = '0;
      end else if (w_xfer) begin
         acc_d = acc_q + LIMIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_len_q <= '0;
         acc_q     <= '0;
      end else begin
         run_len_q <= run_len_d;
         acc_q     <= acc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q     <= 1'b0;
         s1_a_q         <= '0;
         s1_b_q         <= '0;
         s1_sum_q       <= '0;
         res_valid_q    <= 1'b0;
         res_mismatch_q <= 1'b0;
         res_syndrome_q <= '0;
      end else begin
         s1_valid_q <= w_xfer;
         if (w_xfer) begin
            s1_a_q   <= mon.a;
            s1_b_q   <= mon.b;
            s1_sum_q <= mon.dut_sum;
         end
         res_valid_q    <= s1_valid_q;
         res_mismatch_q <= s1_valid_q & w_mis;
         res_syndrome_q <= s1_valid_q ? w_syn : 9'd0;
      end
   end

   // Statistics advance on the same edge that launches res_valid for the vector.
   always_comb begin
      vec_count_d = vec_count_q;
      err_count_d = err_count_q;
      mask_d      = mask_q;
      if (w_start_ok || w_clear_ok) begin
         vec_count_d = '0;
         err_count_d = '0;
         mask_d      = '0;
      end else if (s1_valid_q) begin
         if (!(&vec_count_q)) begin
            vec_count_d = vec_count_q + CNT_W'(1);
         end
         if (w_mis && !(&err_count_q)) begin
            err_count_d = err_count_q + CNT_W'(1);
         end
         mask_d = mask_q | w_syn;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_count_q <= '0;
         err_count_q <= '0;
         mask_q      <= '0;
      end else begin
         vec_count_q <= vec_count_d;
         err_count_q <= err_count_d;
         mask_q      <= mask_d;
      end
   end

`ifdef ADDR8S_MON_FIRST_FAIL_EN
   logic               ff_valid_q, ff_valid_d;
   logic [7:0]         ff_a_q, ff_a_d;
   logic [7:0]         ff_b_q, ff_b_d;
   logic [8:0]         ff_sum_q, ff_sum_d;
   logic [CNT_W-1:0]   ff_index_q, ff_index_d;

   always_comb begin
      ff_valid_d = ff_valid_q;
      ff_a_d     = ff_a_q;
      ff_b_d     = ff_b_q;
      ff_sum_d   = ff_sum_q;
      ff_index_d = ff_index_q;
      if (mon.start || w_clear_ok) begin
         ff_valid_d = 1'b0;
         ff_a_d     = '0;
         ff_b_d     = '0;
         ff_sum_d   = '0;
         ff_index_d = '0;
      end else if (s1_valid_q && w_mis && !ff_valid_q) begin
         ff_valid_d = 1'b1;
         ff_a_d     = s1_a_q;
         ff_b_d     = s1_b_q;
         ff_sum_d   = s1_sum_q;
         ff_index_d = vec_count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ff_valid_q <= 1'b0;
         ff_a_q     <= '0;
         ff_b_q     <= '0;
         ff_sum_q   <= '0;
         ff_index_q <= '0;
      end else begin
         ff_valid_q <= ff_valid_d;
         ff_a_q     <= ff_a_d;
         ff_b_q     <= ff_b_d;
         ff_sum_q   <= ff_sum_d;
         ff_index_q <= ff_index_d;
      end
   end

   assign mon.ff_valid = ff_valid_q;
   assign mon.ff_a     = ff_a_q;
   assign mon.ff_b     = ff_b_q;
   assign mon.ff_sum   = ff_sum_q;
   assign mon.ff_index = ff_index_q;
`else
`endif

   assign mon.in_ready     = w_in_ready;
   assign mon.res_valid    = res_valid_q;
   assign mon.res_mismatch = res_mismatch_q;
   assign mon.res_syndrome = res_syndrome_q;
   assign mon.vec_count    = vec_count_q;
   assign mon.err_count    = err_count_q;
   assign mon.bit_err_mask = mask_q;
   assign mon.busy         = w_busy;
   assign mon.done         = w_done;

endmodule

`default_nettype wire

// File: tb/tb_addr8s_fault_monitor.sv
// Directed and randomized checks of addr8s_fault_monitor against a scoreboard model.
`default_nettype none

module tb_addr8s_fault_monitor;
   localparam int CNT_W   = 16;
   localparam int LIMIT_W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   addr8s_fault_monitor_if #(.CNT_W(CNT_W), .LIMIT_W(LIMIT_W)) bus ();

   addr8s_fault_monitor #(.CNT_W(CNT_W), .LIMIT_W(LIMIT_W)) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus.slave)
   );

   typedef struct {
      int         due;
      logic       mis;
      logic [8:0] syn;
   } exp_t;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   exp_t       pend[$];
   logic [7:0] pa[$];
   logic [7:0] pb[$];
   logic [8:0] ps[$];

   int         m_vec, m_err;
   logic [8:0] m_mask;
   logic       m_ff_valid;
   logic [7:0] m_ff_a, m_ff_b;
   logic [8:0] m_ff_sum;
   int         m_ff_idx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [8:0] golden(input logic [7:0] a, input logic [7:0] b);
      int sa, sb, s;
      sa = $signed(a);
      sb = $signed(b);
      s  = sa + sb;
      return s[8:0];
   endfunction

   task automatic check_result();
      if (pend.size() > 0 && pend[0].due == cyc) begin
         check("res_valid", bus.res_valid, 1);
         check("res_mismatch", bus.res_mismatch, pend[0].mis);
         check("res_syndrome", bus.res_syndrome, pend[0].syn);
         void'(pend.pop_front());
      end else begin
         check("res_valid_idle", bus.res_valid, 0);
      end
   endtask

   task automatic start_run(input int len, input bit with_clear);
      bus.run_len = LIMIT_W'(len);
      bus.start   = 1'b1;
      bus.clear   = with_clear;
      step();
      bus.start   = 1'b0;
      bus.clear   = 1'b0;
      pend.delete();
      m_vec = 0; m_err = 0; m_mask = '0;
      m_ff_valid = 1'b0; m_ff_a = '0; m_ff_b = '0; m_ff_sum = '0; m_ff_idx = 0;
   endtask

   // Offers vectors (preset queue first, then random) and scores every cycle's outputs.
   task automatic feed(input int len, input int err_pct, input int gap_pct, input int extra);
      int acc = 0;
      int offered_after = 0;
      int budget = 0;
      logic [7:0] a, b;
      logic [8:0] s, g;
      while (!(acc == len && pend.size() == 0 && offered_after >= extra) && budget < 2000) begin
         check("in_ready", bus.in_ready, (acc < len));
         check_result();
         bus.in_valid = (acc < len || offered_after < extra) &&
                        ($urandom_range(99) >= gap_pct);
         if (bus.in_valid) begin
            if (pa.size() > 0) begin
               a = pa.pop_front(); b = pb.pop_front(); s = ps.pop_front();
            end else begin
               a = 8'($urandom); b = 8'($urandom);
               s = golden(a, b);
               if ($urandom_range(99) < err_pct) s = s ^ 9'($urandom_range(1, 511));
            end
            bus.a = a; bus.b = b; bus.dut_sum = s;
            if (acc < len) begin
               g = golden(a, b);
               pend.push_back('{due: cyc + 2, mis: (s != g), syn: s ^ g});
               if (s != g && !m_ff_valid) begin
                  m_ff_valid = 1'b1; m_ff_a = a; m_ff_b = b; m_ff_sum = s; m_ff_idx = m_vec;
               end
               m_vec++;
               if (s != g) m_err++;
               m_mask = m_mask | (s ^ g);
               acc++;
            end else begin
               offered_after++;
            end
         end
         step();
         budget++;
      end
      bus.in_valid = 1'b0;
      check("feed_in_budget", (budget < 2000), 1);
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_vec_count"}, bus.vec_count, m_vec);
      check({tag, "_err_count"}, bus.err_count, m_err);
      check({tag, "_mask"}, bus.bit_err_mask, m_mask);
`ifdef ADDR8S_MON_FIRST_FAIL_EN
      check({tag, "_ff_valid"}, bus.ff_valid, m_ff_valid);
      check({tag, "_ff_a"}, bus.ff_a, m_ff_a);
      check({tag, "_ff_b"}, bus.ff_b, m_ff_b);
      check({tag, "_ff_sum"}, bus.ff_sum, m_ff_sum);
      check({tag, "_ff_index"}, bus.ff_index, m_ff_idx);
`endif
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!bus.done && n < 6) begin
         check("drain_res_valid", bus.res_valid, 0);
         step();
         n++;
      end
      check({tag, "_done"}, bus.done, 1);
      check({tag, "_busy"}, bus.busy, 0);
      check_stats(tag);
   endtask

   initial begin
      logic [7:0] ra, rb;
      rst = 1'b1;
      bus.start = 1'b0; bus.clear = 1'b0; bus.run_len = '0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.dut_sum = '0;
      step(); step();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_vec_count", bus.vec_count, 0);
      check("rst_err_count", bus.err_count, 0);
      check("rst_mask", bus.bit_err_mask, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      rst = 1'b0;
      step();

      // Largest positive plus one: exact 9-bit result 0x080.
      pa.push_back(8'h7F); pb.push_back(8'h01); ps.push_back(9'h080);
      start_run(1, 1'b0);
      check("run1_busy", bus.busy, 1);
      feed(1, 0, 0, 0);
      wait_done("run1");

      // Most negative pair, correct then with the sign bit dropped.
      pa.push_back(8'h80); pb.push_back(8'h80); ps.push_back(9'h100);
      pa.push_back(8'h80); pb.push_back(8'h80); ps.push_back(9'h000);
      start_run(2, 1'b0);
      feed(2, 0, 0, 0);
      wait_done("neg");

      // Four back-to-back vectors, faults on the 2nd and 3rd, a 5th offered but refused.
      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         pa.push_back(ra); pb.push_back(rb);
         ps.push_back(golden(ra, rb) ^ ((i == 1) ? 9'h001 : (i == 2) ? 9'h040 : 9'h000));
      end
      start_run(4, 1'b0);
      feed(4, 0, 0, 1);
      wait_done("b2b");

      // start and clear together in DONE: start wins and statistics restart.
      start_run(3, 1'b1);
      check("sc_busy", bus.busy, 1);
      check("sc_done", bus.done, 0);
      check("sc_vec_count", bus.vec_count, 0);
      check("sc_err_count", bus.err_count, 0);
      check("sc_mask", bus.bit_err_mask, 0);
      feed(3, 50, 30, 0);
      wait_done("sc");

      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      check("clr_done", bus.done, 0);
      check("clr_busy", bus.busy, 0);
      check("clr_vec_count", bus.vec_count, 0);
      check("clr_err_count", bus.err_count, 0);
      check("clr_mask", bus.bit_err_mask, 0);

      start_run(0, 1'b0);
      check("len0_done", bus.done, 1);
      check("len0_busy", bus.busy, 0);
      check("len0_in_ready", bus.in_ready, 0);
      check("len0_vec_count", bus.vec_count, 0);

      for (int r = 0; r < 6; r++) begin
         start_run(int'($urandom_range(1, 40)), 1'(r % 2));
         feed(int'(bus.run_len), 30, 25, int'($urandom_range(0, 2)));
         wait_done("rand");
      end

      // Reset one cycle after the 3rd of 4 accepts must discard everything in flight.
      start_run(4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a = 8'($urandom); bus.b = 8'($urandom); bus.dut_sum = 9'($urandom);
         step();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_res_valid", bus.res_valid, 0);
      check("mrst_vec_count", bus.vec_count, 0);
      check("mrst_err_count", bus.err_count, 0);
      check("mrst_mask", bus.bit_err_mask, 0);
      check("mrst_busy", bus.busy, 0);
      check("mrst_done", bus.done, 0);
      check("mrst_in_ready", bus.in_ready, 0);
      step();
      check("mrst_res_valid_next", bus.res_valid, 0);
      check("mrst_vec_count_next", bus.vec_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/addr8s_fault_monitor.md
Name: addr8s_fault_monitor

Overview:
- Sequential checking stage directly downstream of the 8-bit signed adder (A[7:0], B[7:0] -> O[8:0]); consumes the adder's 9-bit result alongside the operands that produced it.
- Computes a golden signed sum, compares it with the adder output, and accumulates run statistics: vectors, mismatches, and a per-bit error mask.
- Used in fault-injection campaigns to measure observable-fault ratios of evolved adder netlists; driven by an operand sequencer and read out by the campaign controller.

Parameters:
- CNT_W, 16, width of the vector and error counters.
- LIMIT_W, 16, width of the run-length input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run; ignored in RUN and DRAIN.
- clear  in  1  returns DONE to IDLE and zeroes statistics; ignored in RUN and DRAIN.
- run_len  in  LIMIT_W  vectors per run; sampled on start.
- in_valid  in  1  operand/result triple valid.
- in_ready  out  1  block accepts the triple this cycle.
- a  in  8  operand A, two's complement.
- b  in  8  operand B, two's complement.
- dut_sum  in  9  adder output O[8:0] for (a, b).
- res_valid  out  1  per-vector result pulse.
- res_mismatch  out  1  dut_sum != golden; qualified by res_valid.
- res_syndrome  out  9  dut_sum XOR golden; qualified by res_valid.
- vec_count  out  CNT_W  vectors checked this run.
- err_count  out  CNT_W  mismatching vectors, saturating.
- bit_err_mask  out  9  sticky OR of all syndromes this run.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.

Behaviour:
- Reset: state IDLE. All outputs 0, including in_ready, res_valid, counters, mask, busy and done. Pipeline valid bits cleared. Reset mid-run discards in-flight vectors; no partial results are kept.
- FSM:
  - IDLE -> RUN on start. Samples run_len, zeroes counters, mask and accepted count.
  - start with run_len = 0 goes IDLE -> DONE next cycle with zero statistics.
  - RUN -> DRAIN in the cycle the run_len-th vector is accepted.
  - DRAIN -> DONE when both pipeline valid bits are 0.
  - DONE -> IDLE on clear, which zeroes the statistics.
  - DONE -> RUN on start; a new run implicitly clears.
  - start and clear asserted together in DONE: start wins.
- Handshake: in_ready = (state == RUN) and (accepted < run_len). A transfer occurs when in_valid and in_ready are both high. No backpressure from downstream.
- Pipeline:
  - Stage 1 registers a, b, dut_sum and a valid bit.
  - Stage 2 computes golden = sext9(a) + sext9(b), full 9-bit signed, never overflows. Registers res_mismatch, res_syndrome and res_valid.
  - Result latency: res_valid asserts exactly 2 cycles after the accepting edge.
  - Sustains one vector per cycle.
- Statistics update in the same edge that asserts res_valid:
  - vec_count += 1.
  - err_count += 1 if mismatch, holding at 2^CNT_W-1 when saturated.
  - bit_err_mask |= syndrome.
  - vec_count saturates identically.
- res_valid is a one-cycle pulse per vector and is 0 when no vector is in flight. Counters and mask are stable in DONE until clear or start.

Optional Feature:
- Macro ADDR8S_MON_FIRST_FAIL_EN.
- Defined: adds outputs ff_valid (1), ff_a (8), ff_b (8), ff_sum (9) and ff_index (CNT_W).
  - Captures operands, dut_sum and the vector index (pre-increment vec_count) of the first mismatch in a run.
  - Holds the capture until start, clear or rst, all of which zero the fields.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- rst, then start with run_len=1; a=0x7F, b=0x01, dut_sum=0x080 -> res_valid 2 cycles later, mismatch=0, syndrome=0x000; done after drain; vec_count=1, err_count=0.
- a=0x80, b=0x80, dut_sum=0x100 -> mismatch=0. Same operands with dut_sum=0x000 -> mismatch=1, syndrome=0x100, bit_err_mask=0x100.
- run_len=4, back-to-back vectors with in_valid held high -> in_ready drops after the 4th accept. Four consecutive res_valid pulses; vec_count=4; 5th vector not accepted.
- Mismatches on vectors 2 (syndrome 0x001) and 3 (syndrome 0x040) of 4 -> err_count=2, bit_err_mask=0x041. With the macro defined: ff_index=1 and ff_a/ff_b of vector 2.
- rst asserted one cycle after accepting vector 3 of 4 -> next cycle IDLE, no res_valid, all counters 0.
- In DONE: start and clear asserted together -> RUN with zeroed statistics. start with run_len=0 -> DONE, vec_count=0.
